// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and defaults for the sequential integer divider controller.
package div_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPrep = 3'd1,
    StCalc = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } div_state_e;

  localparam int unsigned DivDataWDefault  = 32;
  localparam int unsigned DivCyclesDefault = DivDataWDefault;

endpackage

// File: rtl/div_iter_step.sv
// One restoring shift-subtract step: shift {rem,quo} left, subtract divisor, keep if no borrow.
module div_iter_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor_mag,
  output logic [DATA_W-1:0] rem_nxt,
  output logic [DATA_W-1:0] quo_nxt
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] diff;
  logic              borrow;

  always_comb begin
    rem_sh  = {rem, quo[DATA_W-1]};
    // Extra guard bit so the borrow is visible even when the shifted remainder uses bit DATA_W.
    diff    = {1'b0, rem_sh} - {2'b00, divisor_mag};
    borrow  = diff[DATA_W+1];
    quo_nxt = {quo[DATA_W-2:0], ~borrow};
    rem_nxt = borrow ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned divide/modulo sequencer for the EX stage.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = DivDataWDefault,
  parameter int unsigned DIV_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic              req_mod,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              cancel,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ack,
  output logic              busy
);

  localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  div_state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dmag_q, dmag_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              sgn_q, sgn_d;
  logic              mod_q, mod_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;

  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] rem_step, quo_step;
  logic              calc_last;
  logic              div_zero;

  assign calc_last = (cnt_q == CntW'(DIV_CYCLES - 1));
  assign div_zero  = (op_b_q == '0);

  div_iter_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (dmag_q),
    .rem_nxt     (rem_step),
    .quo_nxt     (quo_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cancel) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (req_valid) state_d = StPrep;
        StPrep:  state_d = div_zero ? StDone : StCalc;
        StCalc:  if (calc_last) state_d = StFix;
        StFix:   state_d = StDone;
        StDone:  if (res_ack) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    res_valid = (state_q == StDone);
  end

  assign res_data = res_q;

  // Datapath next-state; a cancel freezes everything so stale work cannot reach res_q.
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sgn_d   = sgn_q;
    mod_d   = mod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    res_d   = res_q;
    a_mag   = (sgn_q && op_a_q[DATA_W-1]) ? ('0 - op_a_q) : op_a_q;
    b_mag   = (sgn_q && op_b_q[DATA_W-1]) ? ('0 - op_b_q) : op_b_q;
    if (!cancel) begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_a_d = src1;
            op_b_d = src2;
            sgn_d  = req_signed;
            mod_d  = req_mod;
          end
        end
        StPrep: begin
          q_neg_d = sgn_q & (op_a_q[DATA_W-1] ^ op_b_q[DATA_W-1]);
          r_neg_d = sgn_q & op_a_q[DATA_W-1];
          if (div_zero) begin
            res_d = mod_q ? op_a_q : '1;
          end else begin
            rem_d  = '0;
            quo_d  = a_mag;
            dmag_d = b_mag;
            cnt_d  = '0;
          end
        end
        StCalc: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CntW'(1);
        end
        StFix: begin
          if (mod_q) res_d = r_neg_q ? ('0 - rem_q) : rem_q;
          else       res_d = q_neg_q ? ('0 - quo_q) : quo_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sgn_q   <= 1'b0;
      mod_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      res_q   <= '0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sgn_q   <= sgn_d;
      mod_q   <= mod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed-vector bench for div_seq_ctrl: result values, latency and control corner cases.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_signed, req_mod;
  logic [31:0] src1, src2;
  logic        cancel;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ack;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(
    .DATA_W     (32),
    .DIV_CYCLES (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_mod    (req_mod),
    .src1       (src1),
    .src2       (src2),
    .cancel     (cancel),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ack    (res_ack),
    .busy       (busy)
  );

  typedef struct {
    string       name;
    bit          sgn;
    bit          md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    @(negedge clk);
    res_ack   = 1'b0;
    req_valid = 1'b0;
  endtask

  // Called at a negedge with the controller idle; lat counts cycles after the accepting edge.
  task automatic run_op(input bit sgn, input bit md, input logic [31:0] a, input logic [31:0] b,
                        input bit ack, output logic [31:0] got, output int lat);
    req_signed = sgn;
    req_mod    = md;
    src1       = a;
    src2       = b;
    req_valid  = 1'b1;
    lat        = -1;
    got        = 32'hxxxx_xxxx;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = i;
        got = res_data;
        break;
      end
    end
    if (ack) do_ack();
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    bit          rv_seen;

    vecs[0]  = '{"u100/7 div",      0, 0, 32'd100,       32'd7,         32'd14,        35};
    vecs[1]  = '{"u100/7 mod",      0, 1, 32'd100,       32'd7,         32'd2,         35};
    vecs[2]  = '{"s-7/2 div",       1, 0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  35};
    vecs[3]  = '{"s-7/2 mod",       1, 1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  35};
    vecs[4]  = '{"s7/-2 mod",       1, 1, 32'd7,         32'hFFFFFFFE,  32'd1,         35};
    vecs[5]  = '{"s7/-2 div",       1, 0, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  35};
    vecs[6]  = '{"u div0 quo",      0, 0, 32'h1234,      32'd0,         32'hFFFFFFFF,  2};
    vecs[7]  = '{"u div0 rem",      0, 1, 32'h1234,      32'd0,         32'h1234,      2};
    vecs[8]  = '{"s div0 rem",      1, 1, 32'hFFFF1234,  32'd0,         32'hFFFF1234,  2};
    vecs[9]  = '{"s ovf div",       1, 0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  35};
    vecs[10] = '{"s ovf mod",       1, 1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         35};
    vecs[11] = '{"u ovf div",       0, 0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         35};
    vecs[12] = '{"u ovf mod",       0, 1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  35};
    vecs[13] = '{"u max/1 div",     0, 0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  35};
    vecs[14] = '{"s-100/-7 div",    1, 0, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        35};
    vecs[15] = '{"s-100/-7 mod",    1, 1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'hFFFFFFFE,  35};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_mod    = 1'b0;
    src1       = '0;
    src2       = '0;
    cancel     = 1'b0;
    res_ack    = 1'b0;
    #1;
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset res_valid", {31'b0, res_valid}, 32'd0);
    check("reset busy",      {31'b0, busy},      32'd0);
    check("reset res_data",  res_data,           32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].md, vecs[i].a, vecs[i].b, 1'b1, got, lat);
      check({vecs[i].name, " data"}, got, vecs[i].exp);
      check({vecs[i].name, " latency"}, lat, vecs[i].lat);
    end

    // Cancel during CALC iteration 10 (cycle 12), then a fresh 5/5 right after.
    req_signed = 1'b0;
    req_mod    = 1'b0;
    src1       = 32'd100;
    src2       = 32'd7;
    req_valid  = 1'b1;
    rv_seen    = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (res_valid) rv_seen = 1'b1;
    end
    check("cancel busy before", {31'b0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    if (res_valid) rv_seen = 1'b1;
    cancel = 1'b0;
    check("cancel no res_valid", {31'b0, rv_seen}, 32'd0);
    check("cancel idle",         {31'b0, req_ready}, 32'd1);
    check("cancel not busy",     {31'b0, busy}, 32'd0);
    run_op(1'b0, 1'b0, 32'd5, 32'd5, 1'b1, got, lat);
    check("after cancel 5/5 data",    got, 32'd1);
    check("after cancel 5/5 latency", lat, 35);

    // Async reset between edges in the middle of CALC.
    req_signed = 1'b0;
    req_mod    = 1'b0;
    src1       = 32'd1000;
    src2       = 32'd3;
    req_valid  = 1'b1;
    repeat (15) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset req_ready", {31'b0, req_ready}, 32'd1);
    check("midreset res_valid", {31'b0, res_valid}, 32'd0);
    check("midreset busy",      {31'b0, busy},      32'd0);
    check("midreset res_data",  res_data,           32'd0);
    req_valid = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    check("post reset idle", {31'b0, busy}, 32'd0);

    // Backpressure: hold result four cycles without ack.
    run_op(1'b0, 1'b0, 32'd100, 32'd7, 1'b0, got, lat);
    check("bp latency", lat, 35);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp data c%0d", k),      res_data,           32'd14);
      check($sformatf("bp res_valid c%0d", k), {31'b0, res_valid}, 32'd1);
      check($sformatf("bp req_ready c%0d", k), {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    // cancel together with res_ack in DONE.
    res_ack = 1'b1;
    cancel  = 1'b1;
    @(negedge clk);
    res_ack   = 1'b0;
    cancel    = 1'b0;
    req_valid = 1'b0;
    check("cancel+ack idle",      {31'b0, req_ready}, 32'd1);
    check("cancel+ack res_valid", {31'b0, res_valid}, 32'd0);

    // cancel with req_valid in IDLE: request must be dropped.
    src1      = 32'd9;
    src2      = 32'd3;
    req_valid = 1'b1;
    cancel    = 1'b1;
    @(negedge clk);
    check("cancel blocks accept", {31'b0, busy}, 32'd0);
    cancel    = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
